digit_scan_ctrl: RTL and testbench

Scan controller for the 8-digit seven-segment display path. It time-multiplexes a 32-bit packed-BCD value across eight digits and drives a 3-bit digit index straight into the 3-to-8 digit-select decoder (`decoder_3to8`). It also drives the 4-bit nibble for the current digit to the segment encoder, with optional leading-zero blanking. It sits directly upstream of the decoder and owns all timing of the display scan.

---
 rtl/digit_scan_ctrl.sv | 51 +++++
 tb/tb_digit_scan_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexes a packed-BCD value across eight display digits with leading-zero blanking
module digit_scan_ctrl #(
  parameter int PRESCALE = 100000,
  parameter int CNT_W    = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic [2:0]  sel,
  output logic [3:0]  nibble,
  output logic        blank,
  output logic        frame
);
  logic [CNT_W-1:0] pcnt;
  logic [2:0]       sel_r;
  logic [31:0]      shadow;
  logic [7:0]       lz;
  logic [7:0]       lz_next;
  logic             frame_r;
  logic             tick;
  assign tick = pcnt == CNT_W'(PRESCALE - 1);
  // digit i is a leading zero when it and every more significant digit are zero; digit 0 always shows
  always_comb begin
    lz_next = '0;
    for (int i = 1; i < 8; i++) lz_next[i] = ~|(value >> (4 * i));
  end
  // prescaler, digit index, frame pulse and captured display data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt    <= '0;
      sel_r   <= '0;
      shadow  <= '0;
      lz      <= 8'hFE;
      frame_r <= 1'b0;
    end else begin
      pcnt    <= tick ? '0 : pcnt + CNT_W'(1);
      sel_r   <= sel_r + 3'(tick);
      frame_r <= tick && sel_r == 3'd7;
      if (load) begin
        shadow <= value;
        lz     <= lz_next;
      end
    end
  end
  assign sel    = sel_r;
  assign nibble = shadow[4*sel_r +: 4];
  assign blank  = blank_lz & lz[sel_r];
  assign frame  = frame_r;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: directed checks of scan timing, load, blanking and reset with PRESCALE=4
module tb_digit_scan_ctrl;
  logic        clk;
  logic        reset_n;
  logic [31:0] value;
  logic        load;
  logic        blank_lz;
  logic [2:0]  sel;
  logic [3:0]  nibble;
  logic        blank;
  logic        frame;
  int          tests;
  int          fails;

  digit_scan_ctrl #(.PRESCALE(4), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .value(value), .load(load), .blank_lz(blank_lz),
    .sel(sel), .nibble(nibble), .blank(blank), .frame(frame)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_sel(input logic [2:0] t);
    int n;
    n = 0;
    while (sel !== t && n < 40) begin
      step();
      n++;
    end
    chk("wait_sel", {29'd0, sel}, {29'd0, t});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    value = 32'h0;
    load = 1'b0;
    blank_lz = 1'b1;
    #3;
    chk("rst_sel", {29'd0, sel}, 0);
    chk("rst_nibble", {28'd0, nibble}, 0);
    chk("rst_blank", {31'd0, blank}, 0);
    chk("rst_frame", {31'd0, frame}, 0);
    step(3);
    chk("rst_hold_sel", {29'd0, sel}, 0);
    reset_n = 1'b1;
    step(3);
    chk("rel_sel_3", {29'd0, sel}, 0);
    chk("rel_frame", {31'd0, frame}, 0);
    step();
    chk("rel_sel_4", {29'd0, sel}, 1);
    for (int k = 2; k < 8; k++) begin
      step(3);
      chk("hold_sel", {29'd0, sel}, k - 1);
      step();
      chk("adv_sel", {29'd0, sel}, k);
    end
    step(4);
    chk("wrap_sel", {29'd0, sel}, 0);
    chk("wrap_frame", {31'd0, frame}, 1);
    step();
    chk("wrap_frame_off", {31'd0, frame}, 0);

    value = 32'h8765_4321;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("scan_nib0", {28'd0, nibble}, 1);
    for (int k = 1; k < 8; k++) begin
      wait_sel(3'(k));
      chk("scan_nib", {28'd0, nibble}, k + 1);
      chk("scan_frame_low", {31'd0, frame}, 0);
    end
    wait_sel(3'd0);
    chk("scan_frame", {31'd0, frame}, 1);
    chk("scan_nib_wrap", {28'd0, nibble}, 1);
    step();
    chk("scan_frame_off", {31'd0, frame}, 0);

    value = 32'h0000_0405;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("lz_nib0", {28'd0, nibble}, 5);
    chk("lz_blank0", {31'd0, blank}, 0);
    for (int k = 1; k < 8; k++) begin
      wait_sel(3'(k));
      chk("lz_blank", {31'd0, blank}, (k >= 3) ? 1 : 0);
    end
    blank_lz = 1'b0;
    #1;
    chk("lz_live_off", {31'd0, blank}, 0);
    blank_lz = 1'b1;
    #1;
    chk("lz_live_on", {31'd0, blank}, 1);

    wait_sel(3'd0);
    value = 32'h0;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("zero_nib0", {28'd0, nibble}, 0);
    chk("zero_blank0", {31'd0, blank}, 0);
    for (int k = 1; k < 8; k++) begin
      wait_sel(3'(k));
      chk("zero_blank", {31'd0, blank}, 1);
    end

    wait_sel(3'd2);
    step(3);
    chk("sim_pre_sel", {29'd0, sel}, 2);
    value = 32'h9999_9999;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("sim_sel", {29'd0, sel}, 3);
    chk("sim_nib", {28'd0, nibble}, 9);
    chk("sim_blank", {31'd0, blank}, 0);

    wait_sel(3'd5);
    step();
    chk("mid_pre_nib", {28'd0, nibble}, 9);
    reset_n = 1'b0;
    #1;
    chk("mid_sel", {29'd0, sel}, 0);
    chk("mid_nib", {28'd0, nibble}, 0);
    chk("mid_blank", {31'd0, blank}, 0);
    chk("mid_frame", {31'd0, frame}, 0);
    step(2);
    reset_n = 1'b1;
    step(3);
    chk("mid_hold_sel", {29'd0, sel}, 0);
    step();
    chk("mid_adv_sel", {29'd0, sel}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
